// File: rtl/seg_scan_controller.sv
// Scan sequencer for a 3-digit multiplexed 7-segment display: slot timing, dead time,
// leading-zero blanking and frame-aligned value swap. Optional macro: SEG_SCAN_DIMMING_EN.
module seg_scan_controller #(
    parameter int SCAN_DIV     = 10000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bcd_in,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        lz_blank,
`ifdef SEG_SCAN_DIMMING_EN
    input  logic [2:0]  brightness,
`endif
    output logic [3:0]  digit_code,
    output logic [1:0]  digit_sel,
    output logic [2:0]  digit_en,
    output logic        frame_done
);

    localparam int              CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   BLANK_LEN = CW'(BLANK_CYCLES);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  slot_q, slot_d;
    logic [11:0] active_q, active_d;
    logic [11:0] pending_q, pending_d;
    logic        pending_full_q, pending_full_d;
    logic        slot_en_q, slot_en_d;
    logic [3:0]  code_q, code_d;
    logic [2:0]  en_q, en_d;
    logic        frame_done_q, frame_done_d;
    logic        ready_q, ready_d;

    logic        wrap, boundary, accept, suppress, show, in_window;
    logic [3:0]  nib;

`ifdef SEG_SCAN_DIMMING_EN
    localparam logic [31:0] DRIVE_LEN = 32'(SCAN_DIV - BLANK_CYCLES);
    logic [2:0]  bright_q, bright_d;
    logic [31:0] win_len, win_off;
`endif

    always_comb begin
        wrap     = (cnt_q == CNT_LAST);
        boundary = wrap && (slot_q == 2'd2);
        accept   = load_valid && ready_q;

        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        slot_d = slot_q;
        if (wrap) begin
            slot_d = (slot_q >= 2'd2) ? 2'd0 : slot_q + 2'd1;
        end

        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        if (boundary && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        // Accept and swap are exclusive: ready is low whenever pending is full.
        if (accept) begin
            pending_d      = bcd_in;
            pending_full_d = 1'b1;
        end

        // Digit for the slot about to start, taken from the post-swap value.
        case (slot_d)
            2'd0:    nib = active_d[3:0];
            2'd1:    nib = active_d[7:4];
            2'd2:    nib = active_d[11:8];
            default: nib = 4'hF;
        endcase
        suppress = lz_blank &&
                   (((slot_d == 2'd2) && (active_d[11:8] == 4'd0)) ||
                    ((slot_d == 2'd1) && (active_d[11:8] == 4'd0) && (active_d[7:4] == 4'd0)));
        show = (nib <= 4'd9) && !suppress;

        slot_en_d = slot_en_q;
        code_d    = code_q;
        if (wrap) begin
            slot_en_d = show;
            code_d    = show ? nib : 4'hF;
        end

        state_d = (cnt_d < BLANK_LEN) ? ST_BLANK : ST_DRIVE;

`ifdef SEG_SCAN_DIMMING_EN
        bright_d  = wrap ? brightness : bright_q;
        win_len   = ((32'(bright_d) + 32'd1) * DRIVE_LEN) >> 3;
        win_off   = 32'(cnt_d - BLANK_LEN);
        in_window = (win_off < win_len);
`else
        in_window = 1'b1;
`endif

        en_d = (state_d == ST_DRIVE && slot_en_d && in_window) ? (3'b001 << slot_d) : 3'b000;
        frame_done_d = boundary;
        ready_d      = !pending_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_BLANK;
            cnt_q          <= '0;
            slot_q         <= 2'd0;
            active_q       <= 12'h000;
            pending_q      <= 12'h000;
            pending_full_q <= 1'b0;
            slot_en_q      <= 1'b1;
            code_q         <= 4'h0;
            en_q           <= 3'b000;
            frame_done_q   <= 1'b0;
            ready_q        <= 1'b1;
`ifdef SEG_SCAN_DIMMING_EN
            bright_q       <= brightness;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            slot_en_q      <= slot_en_d;
            code_q         <= code_d;
            en_q           <= en_d;
            frame_done_q   <= frame_done_d;
            ready_q        <= ready_d;
`ifdef SEG_SCAN_DIMMING_EN
            bright_q       <= bright_d;
`endif
        end
    end

    assign load_ready = ready_q;
    assign digit_code = code_q;
    assign digit_sel  = slot_q;
    assign digit_en   = en_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Scan sequencer for the 3-digit multiplexed 7-segment display. It owns digit selection timing, inter-digit dead time, leading-zero blanking and a buffered update handshake. It feeds the BCD-to-segment decoder (digit_code) and the digit-enable driver (digit_en). The BCD counter logic loads new values through load_valid/load_ready. The controller swaps them in only at frame boundaries, so a frame never mixes two values.

Parameters:
SCAN_DIV, 10000, clock cycles per digit slot (0.83 ms at 12 MHz); must be >= 4
BLANK_CYCLES, 100, dead-time cycles at the start of each slot with all digits off; must be < SCAN_DIV

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
bcd_in  input  12  [11:8]=hundreds, [7:4]=tens, [3:0]=units
load_valid  input  1  bcd_in valid
load_ready  output  1  pending buffer empty, can accept
lz_blank  input  1  1 = suppress leading zeros
digit_code  output  4  BCD code to decoder; 4'hF = blank
digit_sel  output  2  current slot: 0 units, 1 tens, 2 hundreds
digit_en  output  3  one-hot active-high digit strobe, bit n = slot n
frame_done  output  1  one-cycle pulse after each completed frame

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset. All outputs are registered.
- Reset values:
  - digit_en=0, digit_code=0, digit_sel=0, frame_done=0, load_ready=1.
  - Active register = 0, pending empty, slot counter = 0, state = BLANK.
- Slot counter cnt:
  - Width $clog2(SCAN_DIV). Counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, slot advances 0->1->2->0. Slot 3 is unreachable; if ever reached, next slot is 0.
- FSM, two states:
  - BLANK (cnt < BLANK_CYCLES): digit_en=0.
  - DRIVE (cnt >= BLANK_CYCLES): digit_en = one-hot of slot, unless the slot is suppressed.
  - BLANK -> DRIVE when cnt == BLANK_CYCLES-1.
  - DRIVE -> BLANK on wrap.
- digit_sel and digit_code update on the cycle after the wrap, at the start of BLANK. They are therefore stable before digit_en rises.
- Per-digit code:
  - digit_code = active digit for the slot.
  - Any value > 9 is output as 4'hF, and digit_en stays 0 for that slot.
- Leading-zero blanking, when lz_blank=1:
  - hundreds suppressed if it is 0;
  - tens suppressed if hundreds==0 and tens==0;
  - units never suppressed.
  - A suppressed slot keeps full timing (constant frame period) with digit_en=0 and digit_code=4'hF.
  - lz_blank is sampled at each slot start.
- Load handshake:
  - load_ready = !pending_full.
  - Transfer occurs when load_valid && load_ready; bcd_in is captured into pending. There is no ready bypass.
- Frame boundary = wrap while slot==2:
  - If pending is full: active <= pending, pending cleared, load_ready high next cycle.
  - frame_done pulses on the cycle after the boundary, coinciding with slot-0 data from the new active value.
- Simultaneous events:
  - Accept on the boundary cycle while pending was empty: the value goes to pending and is applied at the next boundary.
  - load_valid while pending is full: ignored; the source must hold it.
- Reset mid-operation: aborts the slot immediately, drops any pending value, restores the reset values above.

Optional Feature:
SEG_SCAN_DIMMING_EN
- Defined:
  - Adds input brightness[2:0], sampled at slot start.
  - Drive window D = SCAN_DIV - BLANK_CYCLES.
  - digit_en is asserted only while (cnt - BLANK_CYCLES) < (((brightness+1)*D) >> 3).
  - brightness=7 gives a full window; brightness=0 gives D/8.
  - Slot and frame timing are unchanged.
- Undefined: no brightness port; digit_en is asserted for the whole DRIVE phase.

Test Plan:
1. SCAN_DIV=20, BLANK_CYCLES=4, reset released, no load.
   - digit_en=0 for 4 cycles, then 3'b001 for 16 cycles, digit_code=0.
   - Sequence continues 3'b010, then 3'b100; frame_done pulses every 60 cycles.
2. Load 12'h123, lz_blank=0.
   - After the next boundary, slots show codes 3, 2, 1 with digit_en 001/010/100.
   - load_ready is low from the accept until one cycle after the boundary.
3. Load 12'h007, lz_blank=1.
   - Slot 0: code 7, enabled.
   - Slots 1 and 2: code F, digit_en=0, slot length still 20 cycles.
4. Load 12'h456, then 12'h789 before the boundary, then a third value while load_ready=0.
   - 456 is applied at the first boundary, 789 at the second.
   - The third value is not accepted until load_ready rises.
5. Load 12'h1A3.
   - Tens slot: code F, digit_en stays 0; units shows 3, hundreds shows 1.
6. Assert reset mid-DRIVE of slot 1 with pending full.
   - Next cycle: all outputs at reset values, load_ready=1.
   - The pending value is never displayed.
   - With SEG_SCAN_DIMMING_EN and brightness=3: drive window is 8 of 16 cycles.
